// File: rtl/decode_pkg.sv
// Shared constants and the binary-to-one-hot helper for the decode_2to4 slice.
// Optional build macro affecting this slice: DECODE_ACTIVE_LOW_EN (handled in the top).
package decode_pkg;

   localparam int DEC_SEL_W_DEFAULT = 2;

   // Helper works on the widest supported select; callers zero-extend and slice.
   localparam int DEC_MAX_SEL_W = 6;
   localparam int DEC_MAX_OUT_W = 2 ** DEC_MAX_SEL_W;

   function automatic logic [DEC_MAX_OUT_W-1:0] onehot(
      input logic [DEC_MAX_SEL_W-1:0] sel,
      input logic                     en
   );
      logic [DEC_MAX_OUT_W-1:0] result;
      result = '0;
      if (en) begin
         result[sel] = 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/decode_onehot.sv
// Combinational select/enable to one-hot vector; no state, no polarity handling.
// SEL_W may range from 1 to decode_pkg::DEC_MAX_SEL_W.
module decode_onehot
   import decode_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W_DEFAULT,
   parameter int OUT_W = 2 ** SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [OUT_W-1:0] y
);

   logic [DEC_MAX_OUT_W-1:0] full;

   assign full = onehot(DEC_MAX_SEL_W'(sel), en);
   assign y    = full[OUT_W-1:0];

   // Bits above OUT_W are always zero because sel is zero-extended.
   if (OUT_W < DEC_MAX_OUT_W) begin : g_spare
      logic unused_hi;
      assign unused_hi = |full[DEC_MAX_OUT_W-1:OUT_W];
   end

endmodule

// File: rtl/decode_2to4.sv
// Registered binary-to-one-hot decoder with enable and a valid flag (registered E).
// Build macro DECODE_ACTIVE_LOW_EN: Y becomes active-low and resets to all ones.
module decode_2to4
   import decode_pkg::*;
#(
   parameter int SEL_W = DEC_SEL_W_DEFAULT,
   parameter int OUT_W = 2 ** SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] A,
   input  logic             E,
   output logic [OUT_W-1:0] Y,
   output logic             Y_vld
);

`ifdef DECODE_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] Y_RST = '1;
`else
   localparam logic [OUT_W-1:0] Y_RST = '0;
`endif

   logic [OUT_W-1:0] dec;
   logic [OUT_W-1:0] y_d;
   logic [OUT_W-1:0] y_q;
   logic             y_vld_d;
   logic             y_vld_q;

   decode_onehot #(
      .SEL_W (SEL_W),
      .OUT_W (OUT_W)
   ) u_onehot (
      .sel (A),
      .en  (E),
      .y   (dec)
   );

   always_comb begin
`ifdef DECODE_ACTIVE_LOW_EN
      y_d = ~dec;
`else
      y_d = dec;
`endif
      y_vld_d = E;
   end

   // A and E land in the same register stage, so no intermediate code is stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= Y_RST;
         y_vld_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
      end
   end

   assign Y     = y_q;
   assign Y_vld = y_vld_q;

endmodule

// File: tb/tb_decode_2to4.sv
// Scoreboard bench for decode_2to4; directed vectors with hand-computed results.
// Build with +define+DECODE_ACTIVE_LOW_EN to exercise the active-low, SEL_W = 3 variant.
module tb_decode_2to4;

`ifdef DECODE_ACTIVE_LOW_EN
   localparam int SEL_W = 3;
`else
   localparam int SEL_W = 2;
`endif
   localparam int OUT_W = 2 ** SEL_W;

   logic             clk;
   logic             rst_n;
   logic [SEL_W-1:0] A;
   logic             E;
   logic [OUT_W-1:0] Y;
   logic             Y_vld;

   logic [OUT_W:0] exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   decode_2to4 #(
      .SEL_W (SEL_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .E     (E),
      .Y     (Y),
      .Y_vld (Y_vld)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [OUT_W:0] got, input logic [OUT_W:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   // Hand-written active-high codes are inverted for the active-low build.
   function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] v);
`ifdef DECODE_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic [SEL_W-1:0] a, input logic e, input logic [OUT_W-1:0] exp_y);
      @(negedge clk);
      A = a;
      E = e;
      exp_q.push_back({e, exp_y});
      @(posedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [OUT_W:0] want;
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         check("y_vld_y", {Y_vld, Y}, want);
`ifdef DECODE_ACTIVE_LOW_EN
         check("onehot", {{OUT_W{1'b0}}, ($countones(~Y) <= 1)}, {{OUT_W{1'b0}}, 1'b1});
         if (!Y_vld) check("idle_ones", {1'b0, Y}, {1'b0, {OUT_W{1'b1}}});
`else
         check("onehot", {{OUT_W{1'b0}}, ($countones(Y) <= 1)}, {{OUT_W{1'b0}}, 1'b1});
         if (!Y_vld) check("idle_zero", {1'b0, Y}, {(OUT_W+1){1'b0}});
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [SEL_W-1:0] ra;
      logic             re;
      logic [OUT_W-1:0] rexp;

      rst_n = 1'b0;
      E     = 1'b1;
      A     = '1;
      #3;
      check("reset_at_start", {Y_vld, Y}, {1'b0, pol('0)});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Disabled sweep: A is don't-care.
      for (int i = 0; i < 4; i++) drive(SEL_W'(i), 1'b0, pol(4'b0000));

      // Step sequence, one change per clock.
      drive(2'b00, 1'b0, pol(4'b0000));
      drive(2'b00, 1'b1, pol(4'b0001));
      drive(2'b01, 1'b1, pol(4'b0010));
      drive(2'b11, 1'b1, pol(4'b1000));
      drive(2'b10, 1'b1, pol(4'b0100));

      // Simultaneous E 0->1 and A 00->10.
      drive(2'b00, 1'b0, pol(4'b0000));
      drive(2'b10, 1'b1, pol(4'b0100));

      // Mid-cycle reset while decoding A=11.
      drive(2'b11, 1'b1, pol(4'b1000));
      #5;
      rst_n = 1'b0;
      #1;
      check("reset_mid_cycle", {Y_vld, Y}, {1'b0, pol('0)});
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", {Y_vld, Y}, {1'b0, pol('0)});
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 1'b1, pol(4'b1000));

`ifdef DECODE_ACTIVE_LOW_EN
      drive(3'b101, 1'b1, 8'hDF);
      drive(3'b000, 1'b1, 8'hFE);
      drive(3'b111, 1'b1, 8'h7F);
      drive(3'b101, 1'b0, 8'hFF);
`endif

      // Random A/E; expected code from the decode rule.
      for (int n = 0; n < 1000; n++) begin
         ra   = SEL_W'($urandom_range(0, OUT_W - 1));
         re   = 1'($urandom_range(0, 1));
         rexp = '0;
         if (re) rexp[ra] = 1'b1;
         drive(ra, re, pol(rexp));
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", (OUT_W+1)'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
